// File: rtl/myip_watch_s00_axi.sv
// AXI4-Lite slave exposing four 32-bit watch control registers plus per-register update pulses.
// Latency: write commits on the edge after the last AW/W handshake; read data valid one cycle after AR.
// Backpressure: AW/W stall while B is pending; AR stalls while R is pending.
module myip_watch_s00_axi #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3,
    output logic [3:0]                      reg_wr_pulse
);

    localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB = 2;

    logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];

    logic                          aw_full;
    logic [1:0]                    aw_sel_q;
    logic                          w_full;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]             w_strb_q;

    logic                          aw_hs;
    logic                          w_hs;
    logic                          ar_hs;
    logic                          commit;
    logic                          aw_full_nxt;
    logic                          w_full_nxt;
    logic                          bvalid_nxt;
    logic                          rvalid_nxt;
    logic [1:0]                    wr_sel;
    logic [1:0]                    rd_sel;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]             wr_strb;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_AWPROT, S_AXI_ARPROT};

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign rd_sel = S_AXI_ARADDR[ADDR_LSB+1:ADDR_LSB];

    // Address and data may come from the holding registers or straight off the bus this edge.
    always_comb begin
        commit      = (aw_full || aw_hs) && (w_full || w_hs);
        wr_sel      = aw_full ? aw_sel_q : S_AXI_AWADDR[ADDR_LSB+1:ADDR_LSB];
        wr_data     = w_full  ? w_data_q : S_AXI_WDATA;
        wr_strb     = w_full  ? w_strb_q : S_AXI_WSTRB;
        aw_full_nxt = commit ? 1'b0 : (aw_hs ? 1'b1 : aw_full);
        w_full_nxt  = commit ? 1'b0 : (w_hs  ? 1'b1 : w_full);
        bvalid_nxt  = commit ? 1'b1 : (S_AXI_BREADY ? 1'b0 : S_AXI_BVALID);
        rvalid_nxt  = ar_hs  ? 1'b1 : (S_AXI_RREADY ? 1'b0 : S_AXI_RVALID);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_full       <= 1'b0;
            aw_sel_q      <= '0;
            w_full        <= 1'b0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
        end else begin
            aw_full       <= aw_full_nxt;
            w_full        <= w_full_nxt;
            S_AXI_BVALID  <= bvalid_nxt;
            S_AXI_AWREADY <= !aw_full_nxt && !bvalid_nxt;
            S_AXI_WREADY  <= !w_full_nxt  && !bvalid_nxt;
            if (aw_hs) begin
                aw_sel_q <= S_AXI_AWADDR[ADDR_LSB+1:ADDR_LSB];
            end
            if (w_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= commit ? (4'b0001 << wr_sel) : 4'b0000;
            if (commit) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wr_strb[b]) begin
                        regs[wr_sel][b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // RDATA samples the register array before this edge's commit lands.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            S_AXI_RVALID  <= rvalid_nxt;
            S_AXI_ARREADY <= !rvalid_nxt;
            if (ar_hs) begin
                S_AXI_RDATA <= regs[rd_sel];
            end
        end
    end

    assign S_AXI_BRESP = 2'b00;
    assign S_AXI_RRESP = 2'b00;
    assign slv_reg0    = regs[0];
    assign slv_reg1    = regs[1];
    assign slv_reg2    = regs[2];
    assign slv_reg3    = regs[3];

endmodule
